pipe_carry_adder: RTL and testbench

Parametrised, pipelined successor to the single-bit full-adder carry cell. It adds two WIDTH-bit unsigned operands plus carry-in over STAGES register slices, forwarding a ripple carry between slices. Valid/ready handshakes on both sides allow bubbles and back-pressure. It sits in the datapath library between operand registers and downstream consumers that need registered sum/carry at high clock rates.

---
 rtl/pipe_carry_adder.sv | 113 +++++++++++
 tb/tb_pipe_carry_adder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_carry_adder.sv
// pipe_carry_adder: WIDTH-bit adder split into STAGES ripple slices with valid/ready handshakes.
// Optional unsigned saturation of the final result is enabled by defining PIPE_CARRY_ADDER_SAT_EN.
module pipe_carry_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co
);
   localparam int SW = WIDTH / STAGES;
   localparam int OD = (STAGES > 1) ? STAGES - 1 : 1;

   logic [STAGES-1:0] v_q, v_d, c_q, c_d, adv, uv, uc;
   logic [WIDTH-1:0]  s_q [STAGES];
   logic [WIDTH-1:0]  s_d [STAGES];
   logic [WIDTH-1:0]  us  [STAGES];
   logic [WIDTH-1:0]  sn  [STAGES];
   logic [WIDTH-1:0]  ua  [STAGES];
   logic [WIDTH-1:0]  ub  [STAGES];
   logic [SW:0]       t   [STAGES];
   logic [WIDTH-1:0]  a_q [OD];
   logic [WIDTH-1:0]  a_d [OD];
   logic [WIDTH-1:0]  b_q [OD];
   logic [WIDTH-1:0]  b_d [OD];

   // advance chain: a stage moves when it is empty or the stage after it moves
   always_comb begin
      adv = '0;
      adv[STAGES-1] = !v_q[STAGES-1] || out_ready;
      for (int i = STAGES - 2; i >= 0; i--) adv[i] = !v_q[i] || adv[i+1];
   end

   assign in_ready  = adv[0] && !rst;
   assign out_valid = v_q[STAGES-1];
   assign sum       = s_q[STAGES-1];
   assign co        = c_q[STAGES-1];

   // what each stage sees upstream; forwarded operands are pre-shifted so the live slice sits at bit 0
   always_comb begin
      uv[0] = in_valid;
      uc[0] = ci;
      us[0] = '0;
      ua[0] = a;
      ub[0] = b;
      for (int i = 1; i < STAGES; i++) begin
         uv[i] = v_q[i-1];
         uc[i] = c_q[i-1];
         us[i] = s_q[i-1];
         ua[i] = a_q[i-1];
         ub[i] = b_q[i-1];
      end
   end

   // slice adders; the last slice optionally clamps the whole sum on carry-out
   always_comb begin
      for (int i = 0; i < STAGES; i++) begin
         t[i] = {1'b0, ua[i][SW-1:0]} + {1'b0, ub[i][SW-1:0]} + {{SW{1'b0}}, uc[i]};
         sn[i] = us[i];
         sn[i][i*SW +: SW] = t[i][SW-1:0];
      end
`ifdef PIPE_CARRY_ADDER_SAT_EN
      if (t[STAGES-1][SW]) sn[STAGES-1] = '1;
`endif
   end

   // next state: advancing stages load from upstream, others hold
   always_comb begin
      v_d = v_q;
      c_d = c_q;
      s_d = s_q;
      a_d = a_q;
      b_d = b_q;
      for (int i = 0; i < STAGES; i++) begin
         if (adv[i]) begin
            v_d[i] = uv[i];
            c_d[i] = t[i][SW];
            s_d[i] = sn[i];
         end
      end
      for (int i = 0; i < STAGES - 1; i++) begin
         if (adv[i]) begin
            a_d[i] = ua[i] >> SW;
            b_d[i] = ub[i] >> SW;
         end
      end
   end

   // pipeline registers; reset discards everything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= '0;
         c_q <= '0;
         s_q <= '{default: '0};
         a_q <= '{default: '0};
         b_q <= '{default: '0};
      end else begin
         v_q <= v_d;
         c_q <= c_d;
         s_q <= s_d;
         a_q <= a_d;
         b_q <= b_d;
      end
   end
endmodule

// File: tb/tb_pipe_carry_adder.sv
// tb_pipe_carry_adder: directed and random checks of pipe_carry_adder at 8/2 and 32/4 against an arithmetic model.
module tb_pipe_carry_adder;
`ifdef PIPE_CARRY_ADDER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst8, iv8, ir8, ci8, ov8, or8, co8;
   logic [7:0]  a8, b8, s8;
   logic        rst32, iv32, ir32, ci32, ov32, or32, co32;
   logic [31:0] a32, b32, s32;

   pipe_carry_adder #(.WIDTH(8), .STAGES(2)) u8 (
      .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .ci(ci8),
      .out_valid(ov8), .out_ready(or8), .sum(s8), .co(co8)
   );
   pipe_carry_adder #(.WIDTH(32), .STAGES(4)) u32 (
      .clk(clk), .rst(rst32), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .ci(ci32),
      .out_valid(ov32), .out_ready(or32), .sum(s32), .co(co32)
   );

   int n_cmp = 0, n_bad = 0, n_pop8 = 0;
   logic [32:0] q8 [$];
   logic [32:0] q32 [$];
   logic        hold8 = 1'b0, hold32 = 1'b0;
   logic [8:0]  prev8;
   logic [32:0] prev32;

   function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic c, input int w);
      logic [63:0] f, m;
      m = (64'd1 << w) - 64'd1;
      f = {32'd0, x} + {32'd0, y} + {63'd0, c};
      if (SAT && f[w]) return {1'b1, m[31:0]};
      return {f[w], f[31:0] & m[31:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      #1;
      if (hold8) chk("hold8", 64'({ov8, co8, s8}), 64'({1'b1, prev8}));
      if (hold32) chk("hold32", 64'({ov32, co32, s32}), 64'({1'b1, prev32}));
      if (ov8 && or8) begin
         n_pop8++;
         if (q8.size() == 0) chk("spur8", 64'(ov8), 64'd0);
         else chk("out8", 64'({co8, 24'h0, s8}), 64'(q8.pop_front()));
      end
      if (ov32 && or32) begin
         if (q32.size() == 0) chk("spur32", 64'(ov32), 64'd0);
         else chk("out32", 64'({co32, s32}), 64'(q32.pop_front()));
      end
      if (iv8 && ir8) q8.push_back(ref_add({24'h0, a8}, {24'h0, b8}, ci8, 8));
      if (iv32 && ir32) q32.push_back(ref_add(a32, b32, ci32, 32));
      hold8 = ov8 && !or8;
      prev8 = {co8, s8};
      hold32 = ov32 && !or32;
      prev32 = {co32, s32};
      @(negedge clk);
   endtask

   task automatic wait8(output int lat);
      lat = 1;
      #1;
      while (!ov8 && lat < 10) begin
         @(negedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic wait32(output int lat);
      lat = 1;
      #1;
      while (!ov32 && lat < 12) begin
         @(negedge clk);
         #1;
         lat++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int lat, acc, p0;
      logic taken, seen;
      rst8 = 1'b1; iv8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; or8 = 1'b0;
      rst32 = 1'b1; iv32 = 1'b0; a32 = '0; b32 = '0; ci32 = 1'b0; or32 = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_ir8", 64'(ir8), 64'd0);
      chk("rst_ir32", 64'(ir32), 64'd0);
      repeat (2) @(negedge clk);
      rst8 = 1'b0;
      rst32 = 1'b0;
      #1;
      chk("idle8", 64'({ir8, ov8, co8, s8}), 64'({1'b1, 1'b0, 1'b0, 8'h00}));
      chk("idle32", 64'({ir32, ov32, co32, s32}), 64'({1'b1, 1'b0, 1'b0, 32'h0}));
      @(negedge clk);

      a8 = 8'h3C; b8 = 8'h45; ci8 = 1'b1; iv8 = 1'b1; or8 = 1'b1;
      tick();
      iv8 = 1'b0;
      wait8(lat);
      chk("lat8", 64'(lat), 64'd2);
      chk("sum_lat8", 64'({co8, s8}), 64'({1'b0, 8'h82}));
      tick();

      a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0; iv8 = 1'b1;
      tick();
      iv8 = 1'b0;
      wait8(lat);
      chk("wrap8", 64'({co8, s8}), SAT ? 64'h1FF : 64'h100);
      tick();

      or8 = 1'b0;
      a8 = 8'h10; b8 = 8'h01; iv8 = 1'b1;
      tick();
      a8 = 8'h20; b8 = 8'h02;
      #1;
      chk("bp_ir_second", 64'(ir8), 64'd1);
      tick();
      a8 = 8'h30; b8 = 8'h03;
      #1;
      chk("bp_full8", 64'({ir8, ov8, s8}), 64'({1'b0, 1'b1, 8'h11}));
      repeat (2) begin
         tick();
         #1;
         chk("bp_stall8", 64'({ir8, ov8, s8}), 64'({1'b0, 1'b1, 8'h11}));
      end
      p0 = n_pop8;
      or8 = 1'b1;
      #1;
      chk("bp_ir_comb8", 64'(ir8), 64'd1);
      for (int i = 0; i < 8; i++) begin
         #1;
         taken = iv8 && ir8;
         tick();
         if (taken) iv8 = 1'b0;
      end
      chk("bp_count8", 64'(n_pop8 - p0), 64'd3);
      chk("bp_empty8", 64'(q8.size()), 64'd0);

      acc = 0;
      for (int c = 0; c < 24; c++) begin
         iv32 = (c % 3) == 0;
         a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom);
         #1;
         if (iv32 && ir32) acc++;
         tick();
      end
      iv32 = 1'b1;
      #1;
      chk("bub_full_ir32", 64'(ir32), 64'd0);
      iv32 = 1'b0;
      chk("bub_acc32", 64'(acc), 64'd4);
      or32 = 1'b1;
      repeat (8) tick();
      chk("bub_empty32", 64'(q32.size()), 64'd0);

      or32 = 1'b0;
      repeat (3) begin
         iv32 = 1'b1; a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom);
         tick();
      end
      iv32 = 1'b0;
      rst32 = 1'b1;
      #1;
      chk("mid_rst_ir32", 64'(ir32), 64'd0);
      @(negedge clk);
      q32.delete();
      rst32 = 1'b0;
      or32 = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         #1;
         seen = seen | ov32;
         @(negedge clk);
      end
      chk("mid_rst_flush32", 64'(seen), 64'd0);
      a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; ci32 = 1'b1; iv32 = 1'b1;
      tick();
      iv32 = 1'b0;
      wait32(lat);
      chk("lat32", 64'(lat), 64'd4);
      chk("post_rst32", 64'({co32, s32}), SAT ? 64'h1_FFFF_FFFF : 64'h1_0000_0001);
      tick();

      for (int i = 0; i < 400; i++) begin
         iv8 = ($urandom % 4) != 0; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
         or8 = ($urandom % 3) != 0;
         iv32 = ($urandom % 4) != 0; a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom);
         or32 = ($urandom % 3) != 0;
         if (i % 50 == 0) begin
            a32 = 32'hFFFF_FFFF; b32 = 32'($urandom % 3);
            a8 = 8'hFF; b8 = 8'($urandom % 3);
         end
         tick();
      end
      iv8 = 1'b0; iv32 = 1'b0; or8 = 1'b1; or32 = 1'b1;
      for (int i = 0; i < 20 && (q8.size() != 0 || q32.size() != 0); i++) tick();
      chk("rand_empty8", 64'(q8.size()), 64'd0);
      chk("rand_empty32", 64'(q32.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
